mul_seq_sgn: RTL
================

Name: mul_seq_sgn

Overview:
- Multi-cycle signed (two's-complement) multiplier sequencer.
- Latches one X/Y operand pair through a valid/ready handshake, then walks the widthX+2 Baugh-Wooley partial-product rows, R rows per cycle, into one accumulator.
- Presents the widthX+widthY-bit product on a valid/ready output.
- Area-lean alternative to the fully parallel PP-generator plus adder-tree multiplier, used where throughput is not critical.

Parameters:
- widthX, 8, word width of X (multiplier), >=2
- widthY, 8, word width of Y (multiplicand), >=2
- RowsPerCycle, 2, PP rows summed per BUSY cycle, 1..widthX+2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  block can accept operands
- X_i  in  widthX  signed multiplier
- Y_i  in  widthY  signed multiplicand
- out_valid_o  out  1  product valid
- out_ready_i  in  1  consumer accepts product
- P_o  out  widthX+widthY  signed product
- busy_o  out  1  high in BUSY or DONE

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is synchronous and active-low.
- Widths: widthP = widthX+widthY. Steps N = ceil((widthX+2)/RowsPerCycle).
- Row definitions, each widthP bits, all other bits zero. Row j is taken from the registered operands xr/yr.
  - Row i, for 0 <= i < widthX-1:
    - bit i+k = xr[i]&yr[k], for k < widthY-1
    - bit i+widthY-1 = ~xr[i]&yr[widthY-1]
  - Row widthX-1:
    - bit widthX-1+k = xr[widthX-1]&~yr[k], for k < widthY-1
    - bit widthP-2 = xr[widthX-1]&yr[widthY-1]
  - Row widthX: bit widthP-2 = ~xr[widthX-1], bit widthX-1 = xr[widthX-1].
  - Row widthX+1: bit widthP-1 = 1, bit widthP-2 = ~yr[widthY-1], bit widthY-1 = yr[widthY-1].
- Arithmetic: accumulator is widthP bits; all sums are modulo 2^widthP. Final value equals signed(X)*signed(Y) exactly.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i: latch xr=X_i, yr=Y_i, clear acc, clear row counter cnt=0, go to BUSY.
- BUSY:
  - in_ready_o=0.
  - Each cycle, acc += rows cnt..cnt+R-1; rows with index >= widthX+2 contribute zero. Then cnt += R.
  - After the N-th BUSY cycle, go to DONE.
- DONE:
  - out_valid_o=1, P_o=acc.
  - On out_ready_i: go to IDLE.
  - If out_ready_i is low, P_o and out_valid_o hold stable.
- Latency: in handshake at cycle 0, out_valid_o asserted at cycle N+1. With 8x8 and R=2, that is cycle 6.
- No overlap: a new operand is accepted only in IDLE. This gives one free cycle between transactions.
- X_i and Y_i are ignored outside the IDLE handshake. Operand changes during BUSY have no effect.
- Combinational paths: in_ready_o does not depend combinationally on out_ready_i. out_valid_o is registered-state only.
- Reset (any state, including mid-BUSY or DONE):
  - State goes to IDLE, the in-flight operation is discarded, and no output is produced for it.
  - Reset values: in_ready_o=1, out_valid_o=0, busy_o=0, P_o=0, acc=0, cnt=0, xr=0, yr=0.
- Extreme operands must be exact, e.g. X=Y=most-negative gives +2^(widthX+widthY-2).

Optional Feature:
- Macro: MUL_SEQ_SGN_ZERO_SKIP_EN
- Defined: in IDLE, when in_valid_i is accepted with X_i==0 or Y_i==0, go directly to DONE with acc=0. out_valid_o is asserted the next cycle (latency 1) and BUSY is skipped.
- Undefined: zero operands take the full N BUSY cycles and the result is still 0.

Test Plan (widthX=widthY=8, R=2, N=5):
- X=-128, Y=-128, out_ready_i=1 -> out_valid_o at cycle 6, P_o=0x4000; back in IDLE at cycle 7 with in_ready_o=1.
- X=-1, Y=1 -> P_o=0xFFFF. Then X=127, Y=-128 -> P_o=0xC080. Then X=127, Y=127 -> P_o=0x3F01.
- Backpressure: X=5, Y=-3, out_ready_i=0 for 4 cycles after out_valid_o -> P_o=0xFFF1 held stable, in_ready_o=0 throughout; completes when out_ready_i=1.
- Reset mid-op: drop rst_ni in the 3rd BUSY cycle -> next cycle out_valid_o=0, in_ready_o=1, P_o=0. A following X=3, Y=4 gives P_o=0x000C.
- Operand change during BUSY: X_i/Y_i toggled randomly during BUSY and in_valid_i held high in DONE -> result is unaffected and no second accept occurs until IDLE.
- Zero skip: X=0, Y=-77 -> with macro defined, out_valid_o at cycle 1 with P_o=0; without it, at cycle 6 with P_o=0.

Source files
------------

// File: rtl/mul_seq_sgn.sv
// Multi-cycle signed Baugh-Wooley multiplier: summing RowsPerCycle partial-product rows per cycle into one accumulator.
// Optional build macro MUL_SEQ_SGN_ZERO_SKIP_EN: a zero operand goes straight to DONE and skips BUSY.
module mul_seq_sgn #(
    parameter int unsigned widthX       = 8,
    parameter int unsigned widthY       = 8,
    parameter int unsigned RowsPerCycle = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [widthX-1:0]          X_i,
    input  logic [widthY-1:0]          Y_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [widthX+widthY-1:0]   P_o,
    output logic                       busy_o
);

    localparam int unsigned WidthP  = widthX + widthY;
    localparam int unsigned NumRows = widthX + 2;
    localparam int unsigned CntW    = $clog2(NumRows + RowsPerCycle + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [widthX-1:0]   xr_q, xr_d;
    logic [widthY-1:0]   yr_q, yr_d;
    logic [WidthP-1:0]   acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    // One Baugh-Wooley row; indices outside 0..widthX+1 yield zero.
    function automatic logic [WidthP-1:0] pp_row(input int unsigned j,
                                                 input logic [widthX-1:0] x,
                                                 input logic [widthY-1:0] y);
        logic [WidthP-1:0] row;
        logic [widthX-1:0] xs;
        logic [widthY-1:0] base;
        row  = '0;
        xs   = x >> j;
        base = '0;
        if (j < widthX - 1) begin
            base = {~xs[0] & y[widthY-1], {(widthY-1){xs[0]}} & y[widthY-2:0]};
            row  = WidthP'(base) << j;
        end else if (j == widthX - 1) begin
            base = {x[widthX-1] & y[widthY-1], {(widthY-1){x[widthX-1]}} & ~y[widthY-2:0]};
            row  = WidthP'(base) << j;
        end else if (j == widthX) begin
            row[WidthP-2] = ~x[widthX-1];
            row[widthX-1] = x[widthX-1];
        end else if (j == widthX + 1) begin
            row[WidthP-1] = 1'b1;
            row[WidthP-2] = ~y[widthY-1];
            row[widthY-1] = y[widthY-1];
        end
        return row;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    xr_d    = X_i;
                    yr_d    = Y_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef MUL_SEQ_SGN_ZERO_SKIP_EN
                    if (X_i == '0 || Y_i == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                for (int unsigned r = 0; r < RowsPerCycle; r++) begin
                    acc_d = acc_d + pp_row(32'(cnt_q) + r, xr_q, yr_q);
                end
                cnt_d = cnt_q + CntW'(RowsPerCycle);
                if (32'(cnt_q) + RowsPerCycle >= NumRows) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY) || (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            xr_q        <= '0;
            yr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign P_o         = acc_q;

endmodule
